// File: rtl/seg7_pkg.sv
// Shared types and segment patterns for the 7-segment scan controller.
// Patterns are active-high {g,f,e,d,c,b,a}; the output polarity is applied at the pins.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0   = 7'h3F;
    localparam seg_t SEG_1   = 7'h06;
    localparam seg_t SEG_2   = 7'h5B;
    localparam seg_t SEG_3   = 7'h4F;
    localparam seg_t SEG_4   = 7'h66;
    localparam seg_t SEG_5   = 7'h6D;
    localparam seg_t SEG_6   = 7'h7D;
    localparam seg_t SEG_7   = 7'h07;
    localparam seg_t SEG_8   = 7'h7F;
    localparam seg_t SEG_9   = 7'h6F;
    localparam seg_t SEG_A   = 7'h77;
    localparam seg_t SEG_B   = 7'h7C;
    localparam seg_t SEG_C   = 7'h39;
    localparam seg_t SEG_D   = 7'h5E;
    localparam seg_t SEG_E   = 7'h79;
    localparam seg_t SEG_F   = 7'h71;
    localparam seg_t SEG_OFF = 7'h00;

    function automatic seg_t hex2seg(input logic [3:0] hex);
        seg_t s;
        case (hex)
            4'h0:    s = SEG_0;
            4'h1:    s = SEG_1;
            4'h2:    s = SEG_2;
            4'h3:    s = SEG_3;
            4'h4:    s = SEG_4;
            4'h5:    s = SEG_5;
            4'h6:    s = SEG_6;
            4'h7:    s = SEG_7;
            4'h8:    s = SEG_8;
            4'h9:    s = SEG_9;
            4'hA:    s = SEG_A;
            4'hB:    s = SEG_B;
            4'hC:    s = SEG_C;
            4'hD:    s = SEG_D;
            4'hE:    s = SEG_E;
            default: s = SEG_F;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-high segment pattern decoder.
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output seg_t       seg
);

    assign seg = hex2seg(hex);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed N-digit 7-segment driver with tear-free frame reload and leading-zero blanking.
// Optional PWM brightness gating is compiled in when SEG7_BRIGHTNESS_EN is defined.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int SLOT_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 16,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  wr_valid,
    input  logic [4*N_DIGITS-1:0] wr_data,
    input  logic [N_DIGITS-1:0]   wr_dp,
    input  logic                  lz_blank,
    input  logic [3:0]            brightness,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_start
);

    localparam int SLOT_W  = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int DIGIT_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SLOT_CYCLES - 1);
    localparam logic [SLOT_W-1:0]  BLANK_END  = SLOT_W'(BLANK_CYCLES);
    localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(N_DIGITS - 1);
    localparam logic               POL        = (ACTIVE_LOW != 0);

    logic [SLOT_W-1:0]     slot_cnt_reg;
    logic [DIGIT_W-1:0]    digit_reg;
    logic [4*N_DIGITS-1:0] pend_data_reg;
    logic [N_DIGITS-1:0]   pend_dp_reg;
    logic                  pend_dirty_reg;
    logic [4*N_DIGITS-1:0] act_data_reg;
    logic [N_DIGITS-1:0]   act_dp_reg;
    logic [6:0]            seg_reg;
    logic                  dp_reg;
    logic [N_DIGITS-1:0]   an_reg;
    logic                  frame_start_reg;

    logic slot_wrap;
    logic frame_boundary;
    assign slot_wrap      = (slot_cnt_reg == SLOT_LAST);
    assign frame_boundary = enable && slot_wrap && (digit_reg == DIGIT_LAST);

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            slot_cnt_reg <= '0;
            digit_reg    <= '0;
        end else if (slot_wrap) begin
            slot_cnt_reg <= '0;
            digit_reg    <= (digit_reg == DIGIT_LAST) ? '0 : digit_reg + 1'b1;
        end else begin
            slot_cnt_reg <= slot_cnt_reg + 1'b1;
        end
    end

    // A write landing on the boundary edge stays pending for the following frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_data_reg   <= '0;
            pend_dp_reg     <= '0;
            pend_dirty_reg  <= 1'b0;
            act_data_reg    <= '0;
            act_dp_reg      <= '0;
            frame_start_reg <= 1'b0;
        end else begin
            if (frame_boundary && pend_dirty_reg) begin
                act_data_reg <= pend_data_reg;
                act_dp_reg   <= pend_dp_reg;
            end
            if (wr_valid) begin
                pend_data_reg <= wr_data;
                pend_dp_reg   <= wr_dp;
            end
            if (frame_boundary)
                pend_dirty_reg <= wr_valid;
            else if (wr_valid)
                pend_dirty_reg <= 1'b1;
            frame_start_reg <= frame_boundary;
        end
    end

    logic [3:0]          nib [N_DIGITS];
    logic [N_DIGITS-1:0] upper_zero;
    logic [N_DIGITS-1:0] blanked;
    logic [N_DIGITS-1:0] an_sel;

    // upper_zero[i]: nibbles i..N_DIGITS-1 are all zero
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
        assign nib[gi] = act_data_reg[4*gi +: 4];
        if (gi == N_DIGITS - 1) begin : g_top
            assign upper_zero[gi] = (nib[gi] == 4'h0);
        end else begin : g_mid
            assign upper_zero[gi] = (nib[gi] == 4'h0) && upper_zero[gi+1];
        end
        if (gi == 0) begin : g_first
            assign blanked[gi] = 1'b0;
        end else begin : g_rest
            assign blanked[gi] = lz_blank && upper_zero[gi] && !act_dp_reg[gi];
        end
        assign an_sel[gi] = (digit_reg == DIGIT_W'(gi)) && !blanked[gi];
    end

    logic [3:0] sel_nib;
    logic       sel_dp;
    seg_t       sel_seg;
    assign sel_nib = nib[digit_reg];
    assign sel_dp  = act_dp_reg[digit_reg];

    seg7_hex_decoder u_decoder (
        .hex (sel_nib),
        .seg (sel_seg)
    );

    logic pwm_on;
`ifdef SEG7_BRIGHTNESS_EN
    logic [3:0] pwm_cnt_reg;
    always_ff @(posedge clk) begin
        if (reset || !enable)
            pwm_cnt_reg <= 4'd0;
        else
            pwm_cnt_reg <= pwm_cnt_reg + 4'd1;
    end
    assign pwm_on = (pwm_cnt_reg < brightness);
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;
    assign pwm_on = 1'b1;
`endif

    logic                lit;
    logic [N_DIGITS-1:0] an_next;
    assign lit     = enable && (slot_cnt_reg >= BLANK_END) && pwm_on;
    assign an_next = lit ? an_sel : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_reg <= {7{POL}};
            dp_reg  <= POL;
            an_reg  <= {N_DIGITS{POL}};
        end else begin
            seg_reg <= sel_seg ^ {7{POL}};
            dp_reg  <= sel_dp ^ POL;
            an_reg  <= an_next ^ {N_DIGITS{POL}};
        end
    end

    assign seg         = seg_reg;
    assign dp          = dp_reg;
    assign an          = an_reg;
    assign frame_start = frame_start_reg;

endmodule
